// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake for the PS/2 host transmitter: byte request in,
// busy/done/error status out.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_start,
        input  tx_busy, tx_done, tx_err, err_code
    );

    modport slave (
        input  tx_data, tx_start,
        output tx_busy, tx_done, tx_err, err_code
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data through OE pins.
// Optional macro PS2_TX_RETRY_EN: retry a failed byte up to twice before reporting an error.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 10000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);
    localparam int MAX_CYC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYC - 2);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_DATA, S_ACK, S_RELEASE, S_DONE, S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_last_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    edge_q, edge_d;
    logic [7:0]    data_q, data_d;
    logic [9:0]    frame_q, frame_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          clk_s, data_s, clk_fall, fail, can_retry;
    logic [1:0]    fail_code;

    // Stop bit, odd parity, then data; bit 0 goes out first.
    function automatic logic [9:0] build_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_last_q & ~clk_s;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_q, retry_d;
    assign can_retry = (retry_q != 2'd2);
`else
    assign can_retry = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        edge_d     = edge_q;
        data_d     = data_q;
        frame_d    = frame_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        fail       = 1'b0;
        fail_code  = ERR_TIMEOUT;
`ifdef PS2_TX_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (bus.tx_start) begin
                    state_d    = S_INHIBIT;
                    data_d     = bus.tx_data;
                    frame_d    = build_frame(bus.tx_data);
                    clk_oe_d   = 1'b1;
                    busy_d     = 1'b1;
                    err_code_d = 2'b00;
`ifdef PS2_TX_RETRY_EN
                    retry_d    = 2'd0;
`endif
                end
            end
            S_INHIBIT: begin
                // Start bit goes low one cycle before the clock is released.
                if (cnt_q == INH_DATA) data_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    state_d   = S_START;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                end
            end
            S_START, S_DATA: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b1, frame_q[9:1]};
                    edge_d    = (state_q == S_START) ? 4'd1 : edge_q + 4'd1;
                    if (state_q == S_START) state_d = S_DATA;
                    else if (edge_q == 4'd9) state_d = S_ACK;
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end
            end
            S_ACK: begin
                data_oe_d = 1'b0;
                if (clk_fall) begin
                    if (!data_s) begin
                        state_d = S_RELEASE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_NOACK;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end
            end
            S_RELEASE: begin
                if (clk_s && data_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR: begin
                state_d   = S_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            if (can_retry) begin
                state_d   = S_INHIBIT;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                frame_d   = build_frame(data_q);
`ifdef PS2_TX_RETRY_EN
                retry_d   = retry_q + 2'd1;
`endif
            end else begin
                state_d    = S_ERR;
                err_d      = 1'b1;
                busy_d     = 1'b0;
                err_code_d = fail_code;
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
            end
        end

        // Our own inhibit pulls the clock low, so that fall must not restart the inhibit count.
        if (state_d != state_q || (clk_fall && state_q != S_INHIBIT) ||
            state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
        data_sync_q <= {data_sync_q[0], ps2_data_in};
        clk_last_q  <= clk_s;
        data_q      <= data_d;
        frame_q     <= frame_d;
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_q     <= 4'd0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign bus.tx_busy  = busy_q;
    assign bus.tx_done  = done_q;
    assign bus.tx_err   = err_q;
    assign bus.err_code = err_code_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model receives frames on the
// open-drain lines; a monitor compares pulses and received frames to expectations.
module tb_ps2_host_tx;
    localparam int INHIBIT_CYC = 100;
    localparam int TIMEOUT_CYC = 5000;
    localparam int HALF        = 100;
    localparam int M_ACK = 0, M_NOACK = 1, M_SILENT = 2;
`ifdef PS2_TX_RETRY_EN
    localparam int TRIES = 3;
`else
    localparam int TRIES = 1;
`endif

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        int         ninh;
        logic       timed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_pull = 1'b0, dev_data_pull = 1'b0;
    logic pclk, pdata;

    always #5 clk = ~clk;
    assign pclk  = ~(ps2_clk_oe | dev_clk_pull);
    assign pdata = ~(ps2_data_oe | dev_data_pull);

    ps2_host_tx_if bus ();

    ps2_host_tx #(.INHIBIT_CYC(INHIBIT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ps2_clk_in (pclk),
        .ps2_data_in(pdata),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    exp_t        exp_q[$];
    logic [10:0] fexp_q[$];
    logic [10:0] rx_q[$];
    int          checks = 0;
    int          errors = 0;
    int          dev_mode = M_ACK;
    logic        dev_busy = 1'b0;
    logic        dev_discard = 1'b0;
    int          dev_edges = 0;
    logic [10:0] dev_fr;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Line view of a byte: start 0, data LSB first, parity making the nine bits odd, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Device: on request-to-send, clock 11 pulses, sample on each high phase, ACK on pulse 11.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && pclk && !pdata) begin
                dev_busy = 1'b1;
                if (dev_mode == M_SILENT) begin
                    for (int g = 0; g < 20000 && pclk && !pdata; g++) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                    dev_fr[0] = pdata;
                    for (int k = 1; k <= 11; k++) begin
                        if (k == 11 && dev_mode == M_ACK) dev_data_pull = 1'b1;
                        dev_clk_pull = 1'b1;
                        dev_edges    = k;
                        repeat (HALF) @(negedge clk);
                        dev_clk_pull = 1'b0;
                        repeat (HALF) @(negedge clk);
                        if (k <= 10) dev_fr[k] = pdata;
                    end
                    dev_data_pull = 1'b0;
                    if (!dev_discard) rx_q.push_back(dev_fr);
                end
                dev_busy  = 1'b0;
                dev_edges = 0;
            end
        end
    end

    int          cyc = 0, inh_len = 0, inh_doe = 0, inh_cnt = 0, start_cyc = 0;
    logic        prev_coe = 1'b0, last_doe = 1'b0;
    exp_t        mon_e;
    logic [10:0] mon_f;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                inh_cnt  = 0;
                inh_len  = 0;
                inh_doe  = 0;
                prev_coe = 1'b0;
            end else begin
                if (ps2_clk_oe) begin
                    inh_len++;
                    if (ps2_data_oe) inh_doe++;
                    last_doe = ps2_data_oe;
                end else if (prev_coe) begin
                    check("inhibit_len", 32'(inh_len), 32'(INHIBIT_CYC));
                    check("inhibit_start_bit_last_cycle", 32'(last_doe), 32'd1);
                    check("inhibit_data_low_cycles", 32'(inh_doe), 32'd1);
                    inh_cnt++;
                    start_cyc = cyc;
                    inh_len   = 0;
                    inh_doe   = 0;
                end
                prev_coe = ps2_clk_oe;
                if (bus.tx_done || bus.tx_err) begin
                    check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        check("pulse_kind", 32'({bus.tx_done, bus.tx_err}), mon_e.is_err ? 32'd1 : 32'd2);
                        check("err_code", 32'(bus.err_code), 32'(mon_e.code));
                        check("busy_low_at_pulse", 32'(bus.tx_busy), 32'd0);
                        check("oe_released_at_pulse", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                        check("inhibit_phases", 32'(inh_cnt), 32'(mon_e.ninh));
                        if (mon_e.timed) check("timeout_latency", 32'(cyc - start_cyc), 32'(TIMEOUT_CYC));
                    end
                    inh_cnt = 0;
                end
                if (rx_q.size() != 0) begin
                    mon_f = rx_q.pop_front();
                    check("frame_expected", 32'(fexp_q.size() != 0), 32'd1);
                    if (fexp_q.size() != 0) check("frame_bits", 32'(mon_f), 32'(fexp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, input int mode);
        exp_t e;
        e.is_err = (mode != M_ACK);
        e.code   = (mode == M_ACK) ? 2'b00 : (mode == M_NOACK) ? 2'b10 : 2'b01;
        e.ninh   = (mode == M_ACK) ? 1 : TRIES;
        e.timed  = (mode == M_SILENT);
        exp_q.push_back(e);
        if (mode != M_SILENT)
            for (int i = 0; i < ((mode == M_ACK) ? 1 : TRIES); i++) fexp_q.push_back(model_frame(b));
        dev_mode = mode;
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'($urandom);
        check("busy_rise", 32'(bus.tx_busy), 32'd1);
        check("clk_oe_rise", 32'(ps2_clk_oe), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fexp_q.size() != 0 || dev_busy) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("transfer_completes", 32'(n < 40000), 32'd1);
        repeat (20) @(negedge clk);
    endtask

    int n_wait;

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        rst          = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_busy", 32'(bus.tx_busy), 32'd0);
        check("rst_done", 32'(bus.tx_done), 32'd0);
        check("rst_err", 32'(bus.tx_err), 32'd0);
        check("rst_err_code", 32'(bus.err_code), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED has six ones, so its odd-parity bit is 1; 0xFF has eight, parity 1.
        send(8'hED, M_ACK);
        wait_idle();
        send(8'hFF, M_ACK);
        wait_idle();

        send(8'($urandom), M_NOACK);
        wait_idle();
        check("oe_after_noack", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

        send(8'($urandom), M_SILENT);
        wait_idle();
        check("err_code_held", 32'(bus.err_code), 32'd1);

        // Reset in the middle of data bit 4: lines drop at once, no pulse afterwards.
        dev_discard = 1'b1;
        dev_mode    = M_ACK;
        @(negedge clk);
        bus.tx_data  = 8'($urandom);
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        n_wait = 0;
        while (dev_edges != 5 && n_wait < 20000) begin
            @(negedge clk);
            n_wait++;
        end
        check("reached_bit4", 32'(n_wait < 20000), 32'd1);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_mid_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_mid_busy", 32'(bus.tx_busy), 32'd0);
        check("rst_mid_pulses", 32'({bus.tx_done, bus.tx_err}), 32'd0);
        rst = 1'b1;
        n_wait = 0;
        while (dev_busy && n_wait < 20000) begin
            @(negedge clk);
            n_wait++;
        end
        check("device_idle_after_rst", 32'(dev_busy), 32'd0);
        dev_discard = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_err_code_cleared", 32'(bus.err_code), 32'd0);

        // A second request while busy must leave only 0xED on the line.
        send(8'hED, M_ACK);
        repeat (500) @(negedge clk);
        bus.tx_data  = 8'h55;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        wait_idle();
        repeat (300) @(negedge clk);
        check("ignored_start_busy", 32'(bus.tx_busy), 32'd0);
        check("ignored_start_clk_oe", 32'(ps2_clk_oe), 32'd0);

        for (int i = 0; i < 5; i++) begin
            send(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK);
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
